// File: rtl/d_latch.sv
// Latch-behaviour storage built from a flop: captures d on rising clk while enable=1, holds otherwise.
// Latency 1 cycle (0 with D_LATCH_TRANSPARENT_EN defined); no backpressure, enable alone gates capture.
module d_latch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             loaded
);

  logic [WIDTH-1:0] hold_q;
  logic             loaded_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      loaded_r <= 1'b0;
    end else if (enable) begin
      hold_q   <= d;
      loaded_r <= 1'b1;
    end
  end

`ifdef D_LATCH_TRANSPARENT_EN
  // Reset must win over transparency, so rst_n gates the bypass as well.
  assign q = (rst_n && enable) ? d : hold_q;
`else
  assign q = hold_q;
`endif

  assign q_not  = ~q;
  assign loaded = loaded_r;

endmodule

// File: tb/tb_d_latch.sv
// Directed plus random checks of d_latch against a last-captured-value model.
module tb_d_latch;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d;
  logic         enable;
  logic [W-1:0] q;
  logic [W-1:0] q_not;
  logic         loaded;

  int vectors     = 0;
  int miscompares = 0;

  // Model: value of d at the most recent edge that saw enable=1 since reset.
  logic [W-1:0] m_val;
  logic         m_loaded;

  always #5 clk = ~clk;

  d_latch #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .enable (enable),
    .q      (q),
    .q_not  (q_not),
    .loaded (loaded)
  );

  function automatic logic [W-1:0] exp_q();
    if (!rst_n) return '0;
`ifdef D_LATCH_TRANSPARENT_EN
    if (enable) return d;
`endif
    return m_val;
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] e;
    e = exp_q();
    vectors++;
    assert (q === e) else begin
      miscompares++;
      $error("FAIL %s q: got %h expected %h", tag, q, e);
    end
    vectors++;
    assert (q_not === ~e) else begin
      miscompares++;
      $error("FAIL %s q_not: got %h expected %h", tag, q_not, ~e);
    end
    vectors++;
    assert (loaded === m_loaded) else begin
      miscompares++;
      $error("FAIL %s loaded: got %b expected %b", tag, loaded, m_loaded);
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst_n && enable) begin
      m_val    = d;
      m_loaded = 1'b1;
    end
    #1;
  endtask

  task automatic cycle(input logic [W-1:0] dv, input logic en, input string tag);
    d      = dv;
    enable = en;
    #1;
    check({tag, "_pre"});
    clock_edge();
    check({tag, "_post"});
  endtask

  task automatic reset_pulse(input string tag);
    rst_n    = 1'b0;
    m_val    = '0;
    m_loaded = 1'b0;
    #1;
    check({tag, "_in"});
    #1;
    rst_n = 1'b1;
    #1;
    check({tag, "_out"});
  endtask

  initial begin
    rst_n    = 1'b1;
    enable   = 1'b0;
    d        = '0;
    m_val    = '0;
    m_loaded = 1'b0;

    // Reset asserted before any clock edge while transparent with d=1.
    #1;
    enable = 1'b1;
    d      = 4'h1;
    rst_n  = 1'b0;
    #1;
    check("reset_async");
    cycle(4'h1, 1'b1, "reset_held");
    cycle(4'hf, 1'b1, "reset_held2");

    // Release between edges with enable low.
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_release");

    // Hold: d toggles with enable low, nothing may be captured.
    cycle(4'h0, 1'b0, "hold0");
    cycle(4'h1, 1'b0, "hold1");
    cycle(4'h0, 1'b0, "hold2");
    cycle(4'h1, 1'b0, "hold3");
    cycle(4'h0, 1'b0, "hold4");

    // Capture, then close with d changing on the same cycle.
    cycle(4'h1, 1'b1, "capture");
    cycle(4'h0, 1'b0, "close0");
    cycle(4'h0, 1'b0, "close1");
    cycle(4'h0, 1'b0, "close2");

    // Follow a sequence with enable high.
    cycle(4'h1, 1'b1, "follow1");
    cycle(4'h0, 1'b1, "follow0");
    cycle(4'h1, 1'b1, "follow1b");

    // Unknown data while holding must not disturb q.
    cycle('x, 1'b0, "x_hold");
    cycle('x, 1'b0, "x_hold2");

    // Mid-operation reset, then capture on the first edge after release.
    cycle(4'ha, 1'b1, "pre_reset");
    enable = 1'b1;
    d      = 4'h5;
    reset_pulse("mid_reset");
    clock_edge();
    check("resume");
    cycle(4'h5, 1'b0, "resume_hold");

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_pulse("rand_reset");
      end
      cycle(W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
